// File: rtl/myniosiicpu_cpu_ocimem_monitor.sv
// Nios II OCI debug-monitor RAM: JTAG-side read/write engine sharing a single-port
// 32-bit RAM with a CPU-side Avalon-MM slave window. JTAG traffic has priority.
module myniosiicpu_cpu_ocimem_monitor #(
  parameter int    DEPTH  = 256,
  parameter int    ADDR_W = 8,
  parameter string INIT_F = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAP, WR} state_t;

  // RAM preload is left to the target's memory-initialisation flow; INIT_F names that image.
  localparam bit unusedInitF = (INIT_F != "");

  state_t      r_state;
  logic [8:0]  r_monAReg;
  logic [31:0] r_monDReg;
  logic [31:0] r_wrData;
  logic [31:0] r_ramQ;
  logic [31:0] r_avsReadData;
  logic        r_ready;
  logic        r_error;
  logic        r_cpuRdPend;
  logic        r_rdDelay;
  logic [31:0] r_mem [DEPTH];

  logic w_anyStrobe;
  logic w_inRange;
  logic w_cpuInRange;
  logic w_cpuBlocked;
  logic w_cpuIssue;
  logic w_cpuWrite;
  logic w_jtagWr;
  logic w_unusedJdo;

  assign w_anyStrobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign w_inRange    = (32'(r_monAReg) < 32'(DEPTH));
  assign w_cpuInRange = (32'(avs_address) < 32'(DEPTH));
  assign w_cpuBlocked = (r_state != IDLE) || w_anyStrobe;
  assign w_cpuIssue   = avs_read && !avs_write && !w_cpuBlocked && !r_cpuRdPend;
  assign w_cpuWrite   = avs_write && !w_cpuBlocked && !r_cpuRdPend && w_cpuInRange;
  assign w_jtagWr     = (r_state == WR) && w_inRange;
  assign w_unusedJdo  = ^{jdo[37:36], jdo[2:0]};

  // A CPU read whose issue cycle is done always completes with waitrequest low.
  assign avs_waitrequest = !reset && !r_cpuRdPend && (w_cpuBlocked || (avs_read && !avs_write));

  assign MonDReg       = r_monDReg;
  assign monitor_ready = r_ready;
  assign monitor_error = r_error;
  assign avs_readdata  = r_avsReadData;

  always_ff @(posedge clk) begin
    if (w_jtagWr) begin
      r_mem[r_monAReg[ADDR_W-1:0]] <= r_wrData;
    end else if (w_cpuWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (avs_byteenable[b]) r_mem[avs_address][8*b +: 8] <= avs_writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_monAReg     <= '0;
      r_monDReg     <= '0;
      r_wrData      <= '0;
      r_ramQ        <= '0;
      r_avsReadData <= '0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
      r_cpuRdPend   <= 1'b0;
      r_rdDelay     <= 1'b0;
    end else begin
      if (r_cpuRdPend) begin
        r_cpuRdPend <= 1'b0;
      end else if (w_cpuIssue) begin
        r_cpuRdPend   <= 1'b1;
        r_avsReadData <= w_cpuInRange ? r_mem[avs_address] : '0;
      end

      // A JTAG read accepted while a CPU read completes issues one cycle late.
      case (r_state)
        IDLE: begin
          if (take_action_ocimem_a) begin
            r_monAReg <= jdo[25:17];
            r_ready   <= 1'b0;
            r_rdDelay <= r_cpuRdPend;
            if (jdo[35]) r_error <= 1'b0;
            if (jdo[34]) r_state <= RD_ISSUE;
          end else if (take_action_ocimem_b) begin
            r_wrData <= jdo[34:3];
            r_ready  <= 1'b0;
            r_state  <= WR;
          end else if (take_no_action_ocimem_a) begin
            r_ready   <= 1'b0;
            r_rdDelay <= r_cpuRdPend;
            r_state   <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (r_rdDelay) begin
            r_rdDelay <= 1'b0;
          end else if (w_inRange) begin
            r_ramQ  <= r_mem[r_monAReg[ADDR_W-1:0]];
            r_state <= RD_CAP;
          end else begin
            r_error   <= 1'b1;
            r_monDReg <= 32'hDEAD_BEEF;
            r_ready   <= 1'b1;
            r_state   <= IDLE;
          end
        end
        RD_CAP: begin
          r_monDReg <= r_ramQ;
          r_ready   <= 1'b1;
          r_monAReg <= r_monAReg + 9'd1;
          r_state   <= IDLE;
        end
        WR: begin
          if (!w_inRange) r_error <= 1'b1;
          r_monAReg <= r_monAReg + 9'd1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_anyStrobe && (r_state != IDLE)) r_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_myniosiicpu_cpu_ocimem_monitor.sv
// Self-checking bench for the OCI monitor RAM: a reference memory model feeds
// expected JTAG and CPU read results into scoreboard queues.
module tb_myniosiicpu_cpu_ocimem_monitor;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [37:0]       jdo;
  logic              ta, tna, tb;
  logic [31:0]       MonDReg;
  logic              monitor_ready, monitor_error;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read, avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelMem [DEPTH];
  logic [8:0]  modelAddr;
  logic [31:0] jtagQ [$];
  logic [31:0] cpuQ [$];
  logic [31:0] lastRd;

  myniosiicpu_cpu_ocimem_monitor #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_F("")) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta),
    .take_no_action_ocimem_a (tna),
    .take_action_ocimem_b    (tb),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a, 3 = ocimem_a and ocimem_b together
  task automatic applyStimulus(input int kind, input logic [37:0] data);
    jdo = data;
    ta  = (kind == 0) || (kind == 3);
    tb  = (kind == 1) || (kind == 3);
    tna = (kind == 2);
    tick();
    ta  = 1'b0;
    tb  = 1'b0;
    tna = 1'b0;
  endtask

  task automatic pushJtagRead(input logic [8:0] addr);
    if (addr < DEPTH) begin
      jtagQ.push_back(modelMem[addr[7:0]]);
      modelAddr = addr + 9'd1;
    end else begin
      jtagQ.push_back(32'hDEAD_BEEF);
      modelAddr = addr;
    end
  endtask

  task automatic jtagSetAddr(input logic [8:0] addr, input logic rd, input logic clr);
    applyStimulus(0, {2'b00, clr, rd, 8'h00, addr, 17'h0});
    modelAddr = addr;
    if (rd) pushJtagRead(addr);
  endtask

  task automatic jtagNext();
    applyStimulus(2, '0);
    pushJtagRead(modelAddr);
  endtask

  task automatic jtagWrite(input logic [31:0] data);
    applyStimulus(1, {3'b000, data, 3'b000});
    if (modelAddr < DEPTH) modelMem[modelAddr[7:0]] = data;
    modelAddr = modelAddr + 9'd1;
    tick();
  endtask

  task automatic waitReady(input string tag, input int expLat);
    int n = 0;
    checkOutput({tag, " ready cleared"}, 32'(monitor_ready), 32'd0);
    while (!monitor_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(expLat));
    checkOutput({tag, " scoreboard"}, 32'(jtagQ.size()), 32'd1);
    if (jtagQ.size() > 0) checkOutput({tag, " MonDReg"}, MonDReg, jtagQ.pop_front());
  endtask

  task automatic cpuWrite(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    int n = 0;
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = 1'b1;
    #1;
    while (avs_waitrequest && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("cpu write wait", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) modelMem[addr][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic cpuRead(input logic [7:0] addr, input string tag, input int expWait);
    int n = 0;
    cpuQ.push_back(modelMem[addr]);
    avs_address = addr;
    avs_read    = 1'b1;
    #1;
    while (avs_waitrequest && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput({tag, " wait cycles"}, 32'(n), 32'(expWait));
    checkOutput({tag, " readdata"}, avs_readdata, cpuQ.pop_front());
    @(posedge clk);
    #1;
    avs_read = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    jdo = '0; ta = 1'b0; tna = 1'b0; tb = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    modelAddr = '0;
    #2;
    checkOutput("reset MonDReg", MonDReg, 32'd0);
    checkOutput("reset ready", 32'(monitor_ready), 32'd0);
    checkOutput("reset error", 32'(monitor_error), 32'd0);
    checkOutput("reset readdata", avs_readdata, 32'd0);
    checkOutput("reset waitrequest", 32'(avs_waitrequest), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] JTAG writes and reads");
    jtagSetAddr(9'd5, 1'b0, 1'b0);
    jtagWrite(32'h1234_5678);
    jtagWrite(32'hCAFE_F00D);
    jtagWrite(32'h1111_2222);
    jtagSetAddr(9'd5, 1'b1, 1'b0);
    waitReady("rd5", 2);
    jtagNext();
    waitReady("rd6 autoinc", 2);
    cpuRead(8'd5, "cpu rd5", 1);

    $display("[TB] out-of-range and sticky error");
    jtagSetAddr(9'd300, 1'b1, 1'b0);
    waitReady("rd300", 1);
    checkOutput("oor error", 32'(monitor_error), 32'd1);
    jtagSetAddr(9'd0, 1'b0, 1'b0);
    checkOutput("error sticky", 32'(monitor_error), 32'd1);
    jtagSetAddr(9'd0, 1'b0, 1'b1);
    checkOutput("error cleared", 32'(monitor_error), 32'd0);

    cpuWrite(8'd0, 32'h0BAD_CAFE, 4'hF);
    jtagSetAddr(9'd511, 1'b0, 1'b0);
    jtagWrite(32'hBAD0_0000);
    checkOutput("oor write error", 32'(monitor_error), 32'd1);
    jtagNext();
    waitReady("wrap rd0", 2);
    jtagSetAddr(9'd0, 1'b0, 1'b1);

    jtagSetAddr(9'd7, 1'b1, 1'b0);
    applyStimulus(1, {3'b000, 32'hFFFF_FFFF, 3'b000});
    waitReady("busy rd7", 1);
    checkOutput("busy strobe error", 32'(monitor_error), 32'd1);
    jtagSetAddr(9'd0, 1'b0, 1'b1);
    checkOutput("busy error cleared", 32'(monitor_error), 32'd0);

    $display("[TB] CPU byte-enable write");
    cpuWrite(8'd7, 32'hA5A5_0000, 4'b1100);
    jtagSetAddr(9'd7, 1'b1, 1'b0);
    waitReady("rd7 bytes", 2);
    cpuRead(8'd7, "cpu rd7", 1);
    lastRd = avs_readdata;

    avs_address = 8'd8; avs_writedata = 32'h8888_0008; avs_byteenable = 4'hF;
    avs_read = 1'b1; avs_write = 1'b1;
    #1;
    checkOutput("rd+wr wait", 32'(avs_waitrequest), 32'd0);
    @(posedge clk);
    #1;
    avs_read = 1'b0; avs_write = 1'b0;
    modelMem[8] = 32'h8888_0008;
    checkOutput("rd+wr readdata kept", avs_readdata, lastRd);
    cpuRead(8'd8, "cpu rd8", 1);

    $display("[TB] strobe priority");
    jtagSetAddr(9'd10, 1'b0, 1'b0);
    jtagWrite(32'h0000_00AA);
    applyStimulus(3, {2'b00, 1'b0, 1'b1, 8'h00, 9'd10, 17'h0});
    pushJtagRead(9'd10);
    waitReady("prio rd10", 2);

    $display("[TB] CPU read blocked by JTAG write");
    jtagSetAddr(9'd9, 1'b0, 1'b0);
    jdo = {3'b000, 32'h9999_1234, 3'b000};
    tb = 1'b1;
    avs_address = 8'd9;
    avs_read = 1'b1;
    modelMem[9] = 32'h9999_1234;
    modelAddr = 9'd10;
    cpuQ.push_back(32'h9999_1234);
    n = 0;
    #1;
    while (avs_waitrequest && n < 20) begin
      @(posedge clk);
      #2;
      tb = 1'b0;
      n++;
    end
    checkOutput("blocked rd wait cycles", 32'(n), 32'd3);
    checkOutput("blocked rd readdata", avs_readdata, cpuQ.pop_front());
    @(posedge clk);
    #1;
    avs_read = 1'b0;

    $display("[TB] JTAG read during CPU read completion");
    jtagSetAddr(9'd5, 1'b0, 1'b0);
    cpuQ.push_back(modelMem[5]);
    avs_address = 8'd5;
    avs_read = 1'b1;
    #1;
    checkOutput("cpu issue wait", 32'(avs_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    tna = 1'b1;
    pushJtagRead(modelAddr);
    #1;
    checkOutput("cpu complete wait", 32'(avs_waitrequest), 32'd0);
    checkOutput("cpu complete data", avs_readdata, cpuQ.pop_front());
    @(posedge clk);
    #1;
    tna = 1'b0;
    avs_read = 1'b0;
    waitReady("delayed rd5", 3);

    $display("[TB] reset in RD_CAP");
    applyStimulus(0, {2'b00, 1'b0, 1'b1, 8'h00, 9'd6, 17'h0});
    tick();
    avs_read = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("midreset ready", 32'(monitor_ready), 32'd0);
    checkOutput("midreset MonDReg", MonDReg, 32'd0);
    checkOutput("midreset waitrequest", 32'(avs_waitrequest), 32'd0);
    tick();
    avs_read = 1'b0;
    reset = 1'b0;
    modelAddr = '0;
    tick();
    jtagNext();
    waitReady("post-reset rd0", 2);
    jtagSetAddr(9'd6, 1'b1, 1'b0);
    waitReady("post-reset rd6", 2);

    checkOutput("scoreboard drained", 32'(jtagQ.size() + cpuQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
